// File: rtl/countdown_timer_cnt.sv
// Centisecond countdown timer (MM:SS:CC) clocked by an asynchronous 100 Hz pulse.
// Optional macro AUTO_RELOAD_EN: on reaching zero, reload from the preset and keep running.
module countdown_timer_cnt #(
    parameter int MIN_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pls_in,
    input  logic       clr_pls,
    input  logic       load,
    input  logic       cnt_en,
    input  logic [6:0] pre_cs,
    input  logic [5:0] pre_s,
    input  logic [6:0] pre_m,
    output logic [6:0] cs_cnt,
    output logic [5:0] s_cnt,
    output logic [6:0] m_cnt,
    output logic       busy,
    output logic       done,
    output logic       expire
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] MIN_MAX_C = 7'(MIN_MAX);

    state_t     state_q, state_d;
    logic       sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
    logic [6:0] cs_q, cs_d, m_q, m_d, rl_cs_q, rl_cs_d, rl_m_q, rl_m_d;
    logic [5:0] s_q, s_d, rl_s_q, rl_s_d;
    logic       busy_q, busy_d, done_q, done_d, expire_q, expire_d;

    logic       tick_s, at_zero_s, dec_zero_s, ld_zero_s;
    logic [6:0] ld_cs_s, ld_m_s, dec_cs_s, dec_m_s;
    logic [5:0] ld_s_s, dec_s_s;

    // Synchronizer and edge register; a tick marks a falling edge of the synchronized pulse
    always_comb begin
        sync1_d = pls_in;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        tick_s  = edge_q & ~sync2_q;
    end

    // Clamped preset values and the borrow-chain decrement of the current count
    always_comb begin
        ld_cs_s   = (pre_cs > 7'd99)    ? 7'd99     : pre_cs;
        ld_s_s    = (pre_s  > 6'd59)    ? 6'd59     : pre_s;
        ld_m_s    = (pre_m  > MIN_MAX_C) ? MIN_MAX_C : pre_m;
        ld_zero_s = (ld_cs_s == 7'd0) && (ld_s_s == 6'd0) && (ld_m_s == 7'd0);
        at_zero_s = (cs_q == 7'd0) && (s_q == 6'd0) && (m_q == 7'd0);
        dec_m_s   = m_q;
        if (cs_q != 7'd0) begin
            dec_cs_s = cs_q - 7'd1;
            dec_s_s  = s_q;
        end else begin
            dec_cs_s = 7'd99;
            if (s_q != 6'd0) begin
                dec_s_s = s_q - 6'd1;
            end else begin
                dec_s_s = 6'd59;
                dec_m_s = m_q - 7'd1;
            end
        end
        dec_zero_s = (dec_cs_s == 7'd0) && (dec_s_s == 6'd0) && (dec_m_s == 7'd0);
    end

    // Next-state and next-count logic; priority is clear, then load, then tick
    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        s_d      = s_q;
        m_d      = m_q;
        rl_cs_d  = rl_cs_q;
        rl_s_d   = rl_s_q;
        rl_m_d   = rl_m_q;
        expire_d = 1'b0;
        if (clr_pls) begin
            state_d = IDLE;
            cs_d    = 7'd0;
            s_d     = 6'd0;
            m_d     = 7'd0;
        end else if (load) begin
            cs_d    = ld_cs_s;
            s_d     = ld_s_s;
            m_d     = ld_m_s;
            rl_cs_d = ld_cs_s;
            rl_s_d  = ld_s_s;
            rl_m_d  = ld_m_s;
            state_d = ld_zero_s ? DONE : ARMED;
        end else begin
            case (state_q)
                IDLE:  state_d = IDLE;
                ARMED: state_d = cnt_en ? RUN : ARMED;
                RUN: begin
                    if (!cnt_en) begin
                        state_d = ARMED;
                    end else if (tick_s && !at_zero_s) begin
                        cs_d = dec_cs_s;
                        s_d  = dec_s_s;
                        m_d  = dec_m_s;
                        if (dec_zero_s) begin
                            expire_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                            cs_d = rl_cs_q;
                            s_d  = rl_s_q;
                            m_d  = rl_m_q;
`else
                            state_d = DONE;
`endif
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, count, reload and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            cs_q     <= 7'd0;
            s_q      <= 6'd0;
            m_q      <= 7'd0;
            rl_cs_q  <= 7'd0;
            rl_s_q   <= 6'd0;
            rl_m_q   <= 7'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            edge_q   <= edge_d;
            cs_q     <= cs_d;
            s_q      <= s_d;
            m_q      <= m_d;
            rl_cs_q  <= rl_cs_d;
            rl_s_q   <= rl_s_d;
            rl_m_q   <= rl_m_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            expire_q <= expire_d;
        end
    end

    assign cs_cnt = cs_q;
    assign s_cnt  = s_q;
    assign m_cnt  = m_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign expire = expire_q;

endmodule

// File: tb/tb_countdown_timer_cnt.sv
// Scoreboard bench for countdown_timer_cnt: expected output words are queued when
// stimulus is driven and popped when the outputs are sampled.
module tb_countdown_timer_cnt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pls_in = 1'b0;
    logic       clr_pls = 1'b0;
    logic       load = 1'b0;
    logic       cnt_en = 1'b0;
    logic [6:0] pre_cs = 7'd0;
    logic [5:0] pre_s = 6'd0;
    logic [6:0] pre_m = 7'd0;
    logic [6:0] cs_cnt;
    logic [5:0] s_cnt;
    logic [6:0] m_cnt;
    logic       busy, done, expire;

    int tests = 0;
    int fails = 0;
    logic [22:0] sb[$];
    logic [22:0] exp_v;

    countdown_timer_cnt #(.MIN_MAX(99)) dut (
        .clk(clk), .rst(rst), .pls_in(pls_in), .clr_pls(clr_pls), .load(load),
        .cnt_en(cnt_en), .pre_cs(pre_cs), .pre_s(pre_s), .pre_m(pre_m),
        .cs_cnt(cs_cnt), .s_cnt(s_cnt), .m_cnt(m_cnt),
        .busy(busy), .done(done), .expire(expire)
    );

    always #4 clk = ~clk;

    function automatic logic [22:0] mk(int cs, int s, int m, bit b, bit d, bit e);
        return {7'(cs), 6'(s), 7'(m), b, d, e};
    endfunction

    function automatic logic [22:0] obs();
        return {cs_cnt, s_cnt, m_cnt, busy, done, expire};
    endfunction

    function automatic string fmt(logic [22:0] v);
        return $sformatf("%0d:%0d:%0d busy=%0b done=%0b expire=%0b",
                         v[9:3], v[15:10], v[22:16], v[2], v[1], v[0]);
    endfunction

    // Reference decrement via total centiseconds (independent of a borrow chain)
    function automatic logic [22:0] dec_model(logic [22:0] v);
        int total;
        total = int'(v[9:3]) * 6000 + int'(v[15:10]) * 100 + int'(v[22:16]) - 1;
        return mk(total % 100, (total / 100) % 60, total / 6000, v[2], v[1], v[0]);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        pls_in = 1'b1;
        repeat (3) cyc();
        pls_in = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic do_load(int cs, int s, int m);
        pre_cs = 7'(cs);
        pre_s  = 6'(s);
        pre_m  = 7'(m);
        load   = 1'b1;
        cyc();
        load   = 1'b0;
    endtask

    task automatic clear();
        cnt_en  = 1'b0;
        pls_in  = 1'b1;
        clr_pls = 1'b1;
        cyc();
        clr_pls = 1'b0;
    endtask

    task automatic test_reset();
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        repeat (3) cyc();
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL reset_state got %s exp %s", fmt(obs()), fmt(exp_v)); end
        rst = 1'b0;
        cyc();
        do_load(5, 0, 0);
        cnt_en = 1'b1;
        sb.push_back(mk(5, 0, 0, 1, 0, 0));
        repeat (4) cyc();
        pls_in = 1'b1;
        repeat (4) cyc();
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL reset_no_tick got %s exp %s", fmt(obs()), fmt(exp_v)); end
        clear();
    endtask

    task automatic test_basic();
        do_load(3, 0, 0);
        cnt_en = 1'b1;
        cyc();
        sb.push_back(mk(2, 0, 0, 1, 0, 0));
        sb.push_back(mk(1, 0, 0, 1, 0, 0));
`ifdef AUTO_RELOAD_EN
        sb.push_back(mk(3, 0, 0, 1, 0, 1));
        sb.push_back(mk(3, 0, 0, 1, 0, 0));
`else
        sb.push_back(mk(0, 0, 0, 0, 1, 1));
        sb.push_back(mk(0, 0, 0, 0, 1, 0));
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = sb.pop_front(); tests++;
            if (obs() !== exp_v) begin fails++; $display("FAIL basic_tick%0d got %s exp %s", i + 1, fmt(obs()), fmt(exp_v)); end
        end
        cyc();
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL basic_expire_width got %s exp %s", fmt(obs()), fmt(exp_v)); end
        clear();
    endtask

    task automatic test_borrow();
        do_load(0, 0, 1);
        cnt_en = 1'b1;
        cyc();
        sb.push_back(dec_model(mk(0, 0, 1, 1, 0, 0)));
        tick();
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL borrow got %s exp %s", fmt(obs()), fmt(exp_v)); end
        clear();
    endtask

    task automatic test_clamp();
        sb.push_back(mk(99, 59, 99, 0, 0, 0));
        do_load(120, 63, 127);
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL clamp got %s exp %s", fmt(obs()), fmt(exp_v)); end
        clear();
    endtask

    task automatic test_pause();
        logic [22:0] m;
        m = mk(50, 0, 0, 1, 0, 0);
        do_load(50, 0, 0);
        cnt_en = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            m = dec_model(m);
            tick();
        end
        cnt_en = 1'b0;
        cyc();
        sb.push_back({m[22:3], 3'b000});
        for (int i = 0; i < 5; i++) tick();
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL pause_hold got %s exp %s", fmt(obs()), fmt(exp_v)); end
        cnt_en = 1'b1;
        cyc();
        sb.push_back(dec_model(m));
        tick();
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL pause_resume got %s exp %s", fmt(obs()), fmt(exp_v)); end
        clear();
    endtask

    task automatic test_priority();
        do_load(7, 0, 0);
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        pre_cs = 7'd5;
        clr_pls = 1'b1;
        load = 1'b1;
        cyc();
        clr_pls = 1'b0;
        load = 1'b0;
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL clr_over_load got %s exp %s", fmt(obs()), fmt(exp_v)); end
        do_load(20, 0, 0);
        cnt_en = 1'b1;
        cyc();
        pls_in = 1'b1;
        repeat (3) cyc();
        pls_in = 1'b0;
        repeat (2) cyc();
        sb.push_back(mk(30, 0, 0, 0, 0, 0));
        sb.push_back(mk(30, 0, 0, 1, 0, 0));
        do_load(30, 0, 0);
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL load_drops_tick got %s exp %s", fmt(obs()), fmt(exp_v)); end
        repeat (3) cyc();
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL rerun_after_load got %s exp %s", fmt(obs()), fmt(exp_v)); end
        clear();
    endtask

    task automatic test_zero_preset();
        sb.push_back(mk(0, 0, 0, 0, 1, 0));
        do_load(0, 0, 0);
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL zero_preset got %s exp %s", fmt(obs()), fmt(exp_v)); end
        clear();
    endtask

    task automatic test_auto_reload();
`ifdef AUTO_RELOAD_EN
        sb.push_back(mk(1, 0, 0, 1, 0, 0));
        sb.push_back(mk(2, 0, 0, 1, 0, 1));
        sb.push_back(mk(1, 0, 0, 1, 0, 0));
        sb.push_back(mk(2, 0, 0, 1, 0, 1));
`else
        sb.push_back(mk(1, 0, 0, 1, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 1, 1));
        sb.push_back(mk(0, 0, 0, 0, 1, 0));
        sb.push_back(mk(0, 0, 0, 0, 1, 0));
`endif
        do_load(2, 0, 0);
        cnt_en = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = sb.pop_front(); tests++;
            if (obs() !== exp_v) begin fails++; $display("FAIL reload_tick%0d got %s exp %s", i + 1, fmt(obs()), fmt(exp_v)); end
        end
        clear();
    endtask

    task automatic test_rst_midcount();
        do_load(1, 0, 0);
        cnt_en = 1'b1;
        cyc();
        pls_in = 1'b1;
        repeat (3) cyc();
        pls_in = 1'b0;
        repeat (2) cyc();
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        #1 rst = 1'b1;
        #1;
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL rst_midcount got %s exp %s", fmt(obs()), fmt(exp_v)); end
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        exp_v = sb.pop_front(); tests++;
        if (obs() !== exp_v) begin fails++; $display("FAIL rst_no_expire got %s exp %s", fmt(obs()), fmt(exp_v)); end
        clear();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_clamp();
        test_pause();
        test_priority();
        test_zero_preset();
        test_auto_reload();
        test_rst_midcount();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/countdown_timer_cnt.md
COUNTDOWN_TIMER_CNT -- requirements
Module: countdown_timer_cnt

Interface
REQ-001 SHALL have parameter MIN_MAX, default 99, meaning the largest minute value accepted at preset.
REQ-002 SHALL have port clk  input  1  system clock, 125MHz.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port pls_in  input  1  100Hz pulse, asynchronous to clk; each falling edge is one centisecond tick.
REQ-005 SHALL have port clr_pls  input  1  high-active synchronous clear.
REQ-006 SHALL have port load  input  1  high-active preset load strobe.
REQ-007 SHALL have port cnt_en  input  1  high-active run level; low pauses.
REQ-008 SHALL have ports pre_cs [6:0], pre_s [5:0] and pre_m [6:0], all inputs: preset centiseconds, seconds and minutes.
REQ-009 SHALL have ports cs_cnt [6:0], s_cnt [5:0] and m_cnt [6:0], all outputs: remaining centiseconds, seconds and minutes, registered.
REQ-010 SHALL have port busy  output  1  high in state RUN.
REQ-011 SHALL have port done  output  1  high in state DONE.
REQ-012 SHALL have port expire  output  1  one-clk pulse on reaching zero.

Function
REQ-013 pls_in SHALL pass through a 2-flop synchronizer and then an edge register; tick = edge-register high while sync output low; counters update on the 3rd clk edge after pls_in is first sampled low.
REQ-014 States SHALL be IDLE, ARMED, RUN and DONE, encoded in a single state register.
REQ-015 Transitions: IDLE -load-> ARMED; ARMED -cnt_en=1-> RUN; RUN -cnt_en=0-> ARMED; RUN -count reaches 00:00:00-> DONE; DONE -load-> ARMED; any state -clr_pls-> IDLE.
REQ-016 Priority SHALL be clr_pls > load > tick, evaluated in the same clk cycle; a tick coincident with load or clr_pls SHALL be discarded.
REQ-017 clr_pls SHALL zero all counts and deassert busy, done and expire on the next clk edge.
REQ-018 load SHALL latch the presets into the counts and into a reload register, with clamping: pre_cs>99 -> 99, pre_s>59 -> 59, pre_m>MIN_MAX -> MIN_MAX.
REQ-019 load of an all-zero preset (after clamping) SHALL enter DONE directly, with done=1 and no expire pulse.
REQ-020 load while in RUN SHALL reload the counts and enter ARMED; re-entering RUN requires cnt_en=1 on a later cycle.
REQ-021 The counts SHALL decrement only on a tick while in RUN; in IDLE, ARMED and DONE, ticks SHALL be ignored.
REQ-022 Borrow chain: cs>0 -> cs-1; else cs=99 and s-1; if s was 0 -> s=59 and m-1.
REQ-023 No count SHALL ever underflow; the state SHALL leave RUN on the same edge the counts become 00:00:00.
REQ-024 expire SHALL be asserted for exactly one clk, on the edge on which the counts reach 00:00:00.
REQ-025 Counts SHALL hold their value in ARMED, so pause/resume loses no time.

Reset
REQ-026 rst high SHALL force, asynchronously: state=IDLE, all counts=0, reload register=0, busy=0, done=0, expire=0, and synchronizer/edge flops=0.
REQ-027 Release of rst SHALL NOT itself generate a tick.
REQ-028 rst asserted mid-count SHALL abandon the count with no expire pulse.

Configuration
REQ-029 Macro AUTO_RELOAD_EN: when defined, reaching zero in RUN SHALL pulse expire, reload the counts from the reload register on the same edge and remain in RUN, with DONE entered only via a zero preset.
REQ-030 Without AUTO_RELOAD_EN: reaching zero SHALL enter DONE and hold the counts at 00:00:00.

Verification
REQ-031 Preset 00:00:03, load, then cnt_en=1 with 3 ticks -> counts 02, 01, 00; expire for 1 clk on the 3rd tick; done=1; busy=0.
REQ-032 Preset 01:00:00 with one tick in RUN -> counts 00:59:99.
REQ-033 pre_s=63, pre_cs=120, pre_m=127 with MIN_MAX=99 -> counts 99:59:99 after load.
REQ-034 Preset 00:00:50; after 10 ticks drop cnt_en, give 5 ticks, raise cnt_en, give 1 tick -> counts 00:00:39.
REQ-035 clr_pls and load in the same cycle -> IDLE with counts 0; a tick coincident with load -> counts equal the preset.
REQ-036 With AUTO_RELOAD_EN defined: preset 00:00:02 and 4 ticks -> counts 01, 02, 01, 02 with 2 expire pulses and busy held at 1; without the macro, DONE is entered after tick 2.
